// File: rtl/nodeset_pkg.sv
// Shared definitions for the nodeset array: phase encoding, tag layout and payload flag bits.
package nodeset_pkg;

    localparam int unsigned TAG_W    = 12;
    localparam int unsigned LOCAL_W  = 6;
    localparam int unsigned DEST_W   = TAG_W - LOCAL_W;
    localparam int unsigned FLAG_FFT = 0;
    localparam int unsigned FLAG_DAC = 1;

    typedef enum logic [2:0] {
        PhMark,
        PhMarkDrain,
        PhCount,
        PhCountDrain,
        PhDone
    } phase_e;

    // Upper tag bits select the destination nodeset.
    function automatic logic [DEST_W-1:0] tag_dest(input logic [TAG_W-1:0] tag);
        return tag[TAG_W-1:LOCAL_W];
    endfunction

endpackage

// File: rtl/nodeset_router_if.sv
// Request/delivery bus between the nodeset array (master) and the router (slave).
interface nodeset_router_if #(
    parameter int unsigned NUM_SETS     = 8,
    parameter int unsigned NUM_PATHS_DW = 16
);
    import nodeset_pkg::*;

    localparam int unsigned PW = NUM_PATHS_DW + 2;

    logic [NUM_SETS-1:0]         i_src_vld;
    logic [NUM_SETS*PW-1:0]      i_src_payload;
    logic [NUM_SETS*TAG_W-1:0]   i_src_nodenum;
    logic [NUM_SETS-1:0]         o_src_ack;
    logic [NUM_SETS-1:0]         o_dst_vld;
    logic [NUM_SETS*PW-1:0]      o_dst_payload;
    logic [NUM_SETS*LOCAL_W-1:0] o_dst_nodenum;

    modport master (
        output i_src_vld, i_src_payload, i_src_nodenum,
        input  o_src_ack, o_dst_vld, o_dst_payload, o_dst_nodenum
    );

    modport slave (
        input  i_src_vld, i_src_payload, i_src_nodenum,
        output o_src_ack, o_dst_vld, o_dst_payload, o_dst_nodenum
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer (modulo N) wins.
module rr_arbiter #(
    parameter int unsigned N = 8,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int unsigned j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j[IW-1:0]]) begin
                any_o             = 1'b1;
                gnt_o[j[IW-1:0]]  = 1'b1;
                idx_o             = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/nodeset_router.sv
// Routes child-notification requests to destination nodesets and sequences the global phase.
module nodeset_router
    import nodeset_pkg::*;
#(
    parameter int unsigned NUM_SETS     = 8,
    parameter int unsigned NUM_PATHS_DW = 16,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    nodeset_router_if.slave     bus,
    input  logic                i_load_done,
    input  logic [NUM_SETS-1:0] i_reqs_complete,
    output logic                o_start_counting,
    output logic                o_done,
    output logic                o_bad_dest
);

    localparam int unsigned PW = NUM_PATHS_DW + 2;
    localparam int unsigned IW = $clog2(NUM_SETS);
    localparam int unsigned CW = $clog2(QUIET_CYCLES + 1);

    logic [DEST_W-1:0]   src_dest [NUM_SETS];
    logic [NUM_SETS-1:0] src_bad;
    logic [NUM_SETS-1:0] dst_req  [NUM_SETS];
    logic [NUM_SETS-1:0] dst_gnt  [NUM_SETS];
    logic [IW-1:0]       dst_idx  [NUM_SETS];
    logic [NUM_SETS-1:0] dst_any;
    logic [IW-1:0]       ptr_q    [NUM_SETS];
    logic [IW-1:0]       ptr_d    [NUM_SETS];
    logic [NUM_SETS-1:0] ack;

    logic [NUM_SETS-1:0]         dst_vld_q;
    logic [NUM_SETS*PW-1:0]      dst_pay_q;
    logic [NUM_SETS*LOCAL_W-1:0] dst_loc_q;
    logic                        bad_q;

    phase_e        phase_q;
    logic [CW-1:0] quiet_q, quiet_d;
    logic          quiet_done;
    logic          idle;
    logic          start_q, done_q;

    // dst_req[d][s]: source s is requesting destination d this cycle.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            src_dest[s] = tag_dest(bus.i_src_nodenum[s*TAG_W +: TAG_W]);
            src_bad[s]  = bus.i_src_vld[s] && (32'(src_dest[s]) >= NUM_SETS);
        end
        for (int d = 0; d < NUM_SETS; d++) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                dst_req[d][s] = bus.i_src_vld[s] && (32'(src_dest[s]) == d);
            end
        end
    end

    for (genvar g = 0; g < NUM_SETS; g++) begin : g_dst
        rr_arbiter #(
            .N(NUM_SETS)
        ) u_arb (
            .req_i(dst_req[g]),
            .ptr_i(ptr_q[g]),
            .gnt_o(dst_gnt[g]),
            .idx_o(dst_idx[g]),
            .any_o(dst_any[g])
        );
    end

    // Bad-destination requests are acked so their source moves on; they are dropped here.
    always_comb begin
        ack = src_bad;
        for (int d = 0; d < NUM_SETS; d++) begin
            ack = ack | dst_gnt[d];
            ptr_d[d] = ptr_q[d];
            if (dst_any[d]) begin
                ptr_d[d] = (32'(dst_idx[d]) == NUM_SETS - 1) ? '0 : dst_idx[d] + 1'b1;
            end
        end
    end

    assign bus.o_src_ack = rst_n ? ack : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dst_vld_q <= '0;
            dst_pay_q <= '0;
            dst_loc_q <= '0;
            bad_q     <= 1'b0;
            for (int d = 0; d < NUM_SETS; d++) begin
                ptr_q[d] <= '0;
            end
        end else begin
            dst_vld_q <= dst_any;
            bad_q     <= bad_q | (|src_bad);
            for (int d = 0; d < NUM_SETS; d++) begin
                ptr_q[d] <= ptr_d[d];
                if (dst_any[d]) begin
                    dst_pay_q[d*PW +: PW] <= bus.i_src_payload[32'(dst_idx[d])*PW +: PW];
                    dst_loc_q[d*LOCAL_W +: LOCAL_W] <=
                        bus.i_src_nodenum[32'(dst_idx[d])*TAG_W +: LOCAL_W];
                end
            end
        end
    end

    assign bus.o_dst_vld     = dst_vld_q;
    assign bus.o_dst_payload = dst_pay_q;
    assign bus.o_dst_nodenum = dst_loc_q;
    assign o_bad_dest        = bad_q;

    assign idle = (&i_reqs_complete) && !(|bus.i_src_vld) && !(|dst_vld_q);

    always_comb begin
        quiet_d = '0;
        if (idle) begin
            quiet_d = (quiet_q == CW'(QUIET_CYCLES)) ? quiet_q : quiet_q + 1'b1;
        end
    end

    // Transition on the cycle the counter reaches the threshold, so the phase flag
    // appears QUIET_CYCLES+1 cycles after load_done on an idle array.
    assign quiet_done = (quiet_d == CW'(QUIET_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PhMark;
            quiet_q <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            quiet_q <= quiet_d;
            unique case (phase_q)
                PhMark: begin
                    quiet_q <= '0;
                    if (i_load_done) begin
                        phase_q <= PhMarkDrain;
                    end
                end
                PhMarkDrain: begin
                    if (quiet_done) begin
                        phase_q <= PhCount;
                        start_q <= 1'b1;
                        quiet_q <= '0;
                    end
                end
                PhCount: begin
                    phase_q <= PhCountDrain;
                    quiet_q <= '0;
                end
                PhCountDrain: begin
                    if (quiet_done) begin
                        phase_q <= PhDone;
                        done_q  <= 1'b1;
                        quiet_q <= '0;
                    end
                end
                PhDone: begin
                    quiet_q <= '0;
                end
                default: begin
                    phase_q <= PhMark;
                end
            endcase
        end
    end

    assign o_start_counting = start_q;
    assign o_done           = done_q;

endmodule
